// File: rtl/axi_lite_regcheck_master.sv
// AXI4-Lite register write/readback checker master.
// Writes a seeded incrementing pattern to NUM_REGS consecutive slave registers,
// reads each one back, compares, and reports an error count plus the first failure.
// Optional build macro: AXI_REGCHK_RESP_CHECK_EN -- also counts non-OKAY bresp/rresp
// as errors and raises the sticky resp_err flag.
module axi_lite_regcheck_master #(
   parameter int                              C_M_AXI_ADDR_WIDTH = 32,
   parameter int                              C_M_AXI_DATA_WIDTH = 32,
   parameter int                              NUM_REGS           = 4,
   parameter logic [C_M_AXI_ADDR_WIDTH-1:0]   BASE_ADDR          = '0,
   parameter int                              ADDR_STRIDE        = 4,
   parameter logic [31:0]                     PATTERN_INC        = 32'h11111111
) (
   input  logic                                ACLK,
   input  logic                                ARESET,
   input  logic                                start,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]       seed,
   output logic                                busy,
   output logic                                done,
   output logic                                pass,
   output logic [7:0]                          err_count,
   output logic [7:0]                          fail_index,
   output logic [C_M_AXI_DATA_WIDTH-1:0]       fail_rdata,
   output logic                                resp_err,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]       m_axi_awaddr,
   output logic [2:0]                          m_axi_awprot,
   output logic                                m_axi_awvalid,
   input  logic                                m_axi_awready,
   output logic [C_M_AXI_DATA_WIDTH-1:0]       m_axi_wdata,
   output logic [C_M_AXI_DATA_WIDTH/8-1:0]     m_axi_wstrb,
   output logic                                m_axi_wvalid,
   input  logic                                m_axi_wready,
   input  logic [1:0]                          m_axi_bresp,
   input  logic                                m_axi_bvalid,
   output logic                                m_axi_bready,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]       m_axi_araddr,
   output logic [2:0]                          m_axi_arprot,
   output logic                                m_axi_arvalid,
   input  logic                                m_axi_arready,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]       m_axi_rdata,
   input  logic [1:0]                          m_axi_rresp,
   input  logic                                m_axi_rvalid,
   output logic                                m_axi_rready
);
   localparam int AW    = C_M_AXI_ADDR_WIDTH;
   localparam int DW    = C_M_AXI_DATA_WIDTH;
   localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam logic [DW-1:0]    INC    = DW'(PATTERN_INC);
   localparam logic [AW-1:0]    STRIDE = AW'(ADDR_STRIDE);
   localparam logic [IDX_W-1:0] LAST   = IDX_W'(NUM_REGS - 1);

   typedef enum logic [2:0] {S_IDLE, S_WRITE, S_WRESP, S_RADDR, S_RDATA, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [DW-1:0]     data_q, data_d;
   logic [AW-1:0]     addr_q, addr_d;
   logic [7:0]        err_q, err_d;
   logic [7:0]        fidx_q, fidx_d;
   logic [DW-1:0]     frd_q, frd_d;
   logic              pass_q, pass_d;
   logic              rerr_q, rerr_d;
   logic              aw_done_q, aw_done_d;
   logic              w_done_q, w_done_d;
   logic              bad;
   logic [DW-1:0]     bad_rdata;

   wire aw_hs   = m_axi_awvalid & m_axi_awready;
   wire w_hs    = m_axi_wvalid & m_axi_wready;
   wire wr_exit = (aw_done_q | aw_hs) & (w_done_q | w_hs);
   wire last    = (idx_q == LAST);

`ifndef AXI_REGCHK_RESP_CHECK_EN
   // Responses are deliberately not inspected in this build.
   logic unused_resp;
   assign unused_resp = ^{m_axi_bresp, m_axi_rresp};
`endif

   // Payloads come straight from the registered pattern, so they are stable while valid.
   assign m_axi_awaddr = addr_q;
   assign m_axi_araddr = addr_q;
   assign m_axi_wdata  = data_q;
   assign m_axi_wstrb  = '1;
   assign m_axi_awprot = 3'b000;
   assign m_axi_arprot = 3'b000;
   assign pass         = pass_q;
   assign err_count    = err_q;
   assign fail_index   = fidx_q;
   assign fail_rdata   = frd_q;
   assign resp_err     = rerr_q;

   // FSM state register
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // FSM next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start)          state_d = S_WRITE;
         S_WRITE: if (wr_exit)        state_d = S_WRESP;
         S_WRESP: if (m_axi_bvalid)   state_d = S_RADDR;
         S_RADDR: if (m_axi_arready)  state_d = S_RDATA;
         S_RDATA: if (m_axi_rvalid)   state_d = last ? S_DONE : S_WRITE;
         S_DONE:                      state_d = S_IDLE;
         default:                     state_d = S_IDLE;
      endcase
   end

   // FSM outputs: valids/readies decode from state so reset drops them asynchronously
   always_comb begin
      m_axi_awvalid = 1'b0;
      m_axi_wvalid  = 1'b0;
      m_axi_bready  = 1'b0;
      m_axi_arvalid = 1'b0;
      m_axi_rready  = 1'b0;
      busy          = 1'b0;
      done          = 1'b0;
      case (state_q)
         S_WRITE: begin m_axi_awvalid = ~aw_done_q; m_axi_wvalid = ~w_done_q; busy = 1'b1; end
         S_WRESP: begin m_axi_bready  = 1'b1; busy = 1'b1; end
         S_RADDR: begin m_axi_arvalid = 1'b1; busy = 1'b1; end
         S_RDATA: begin m_axi_rready  = 1'b1; busy = 1'b1; end
         S_DONE:  done = 1'b1;
         default: ;
      endcase
   end

   // Datapath next-state: pattern/address stepping, handshake tracking, error capture
   always_comb begin
      idx_d     = idx_q;
      data_d    = data_q;
      addr_d    = addr_q;
      err_d     = err_q;
      fidx_d    = fidx_q;
      frd_d     = frd_q;
      pass_d    = pass_q;
      rerr_d    = rerr_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      bad       = 1'b0;
      bad_rdata = '0;
      case (state_q)
         S_IDLE: if (start) begin
            data_d = seed;
            addr_d = BASE_ADDR;
            idx_d  = '0;
            err_d  = '0;
            fidx_d = '0;
            frd_d  = '0;
            pass_d = 1'b0;
            rerr_d = 1'b0;
         end
         S_WRITE: begin
            // AW and W complete independently; remember whichever finished first.
            if (aw_hs) aw_done_d = 1'b1;
            if (w_hs)  w_done_d  = 1'b1;
            if (wr_exit) begin
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
            end
         end
`ifdef AXI_REGCHK_RESP_CHECK_EN
         S_WRESP: if (m_axi_bvalid && m_axi_bresp != 2'b00) begin
            bad    = 1'b1;
            rerr_d = 1'b1;
         end
`endif
         S_RDATA: if (m_axi_rvalid) begin
            bad_rdata = m_axi_rdata;
            if (m_axi_rdata != data_q) bad = 1'b1;
`ifdef AXI_REGCHK_RESP_CHECK_EN
            if (m_axi_rresp != 2'b00) begin
               bad    = 1'b1;
               rerr_d = 1'b1;
            end
`endif
            if (!last) begin
               idx_d  = idx_q + 1'b1;
               data_d = data_q + INC;
               addr_d = addr_q + STRIDE;
            end
         end
         default: ;
      endcase
      // Only the first failing response is captured; the count saturates.
      if (bad) begin
         if (err_q == 8'd0) begin
            fidx_d = 8'(idx_q);
            frd_d  = bad_rdata;
         end
         if (err_q != 8'hFF) err_d = err_q + 8'd1;
      end
      if (state_q == S_RDATA && m_axi_rvalid && last) pass_d = (err_d == 8'd0);
   end

   // Datapath registers
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         idx_q     <= '0;
         data_q    <= '0;
         addr_q    <= '0;
         err_q     <= '0;
         fidx_q    <= '0;
         frd_q     <= '0;
         pass_q    <= 1'b0;
         rerr_q    <= 1'b0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
      end else begin
         idx_q     <= idx_d;
         data_q    <= data_d;
         addr_q    <= addr_d;
         err_q     <= err_d;
         fidx_q    <= fidx_d;
         frd_q     <= frd_d;
         pass_q    <= pass_d;
         rerr_q    <= rerr_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
      end
   end
endmodule

// File: tb/tb_axi_lite_regcheck_master.sv
// Bench for axi_lite_regcheck_master: randomized-delay AXI4-Lite RAM slave with
// fault injection, and a pattern-level reference model of the expected results.
module tb_axi_lite_regcheck_master;
   localparam logic [31:0] BASE = 32'h0;
   localparam logic [31:0] INC  = 32'h11111111;

   logic        ACLK = 1'b0;
   logic        ARESET = 1'b1;
   logic        start = 1'b0;
   logic [31:0] seed = '0;
   logic        busy, done, pass, resp_err;
   logic [7:0]  err_count, fail_index;
   logic [31:0] fail_rdata;
   logic [31:0] awaddr, wdata, araddr, rdata;
   logic [2:0]  awprot, arprot;
   logic [3:0]  wstrb;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready;
   logic [1:0]  bresp, rresp;

   axi_lite_regcheck_master dut (
      .ACLK(ACLK), .ARESET(ARESET), .start(start), .seed(seed),
      .busy(busy), .done(done), .pass(pass), .err_count(err_count),
      .fail_index(fail_index), .fail_rdata(fail_rdata), .resp_err(resp_err),
      .m_axi_awaddr(awaddr), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
      .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
      .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
      .m_axi_araddr(araddr), .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
      .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
   );

   always #5 ACLK = ~ACLK;

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // slave configuration and fault injection
   int  aw_dly, w_dly, ar_dly, b_dly, r_min, r_max, stuck_reg, berr_reg;
   bit  pre_rdy;
   logic [31:0] seed_m;

   // slave bookkeeping
   logic [31:0] mem [4];
   logic [31:0] aw_a, w_d, r_a, p_awa, p_wd, p_ara;
   bit   aw_got, w_got, b_pend, r_pend, p_awv, p_wv, p_arv;
   bit   aw_hs_p, w_hs_p, ar_hs_p, b_hs_p, r_hs_p;
   int   aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt, r_dly, wr_i, viol, busy_cyc, done_cyc;
   logic [1:0] b_code;

   function automatic logic [31:0] exp_data(input int i);
      return seed_m + 32'(i) * INC;
   endfunction

   function automatic logic [31:0] exp_addr(input int i);
      return BASE + 32'(i) * 32'd4;
   endfunction

   // AXI4-Lite RAM slave, acts on the falling edge: commit last edge's handshakes, then set readies/valids
   initial begin
      awready = 0; wready = 0; bvalid = 0; bresp = 0; arready = 0; rvalid = 0; rdata = 0; rresp = 0;
      aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0; p_awv = 0; p_wv = 0; p_arv = 0;
      aw_hs_p = 0; w_hs_p = 0; ar_hs_p = 0; b_hs_p = 0; r_hs_p = 0;
      aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0; r_dly = 0; b_code = 0;
      wr_i = 0; viol = 0; busy_cyc = 0; done_cyc = 0;
      forever begin
         @(negedge ACLK);
         if (ARESET) begin
            awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
            aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0; p_awv = 0; p_wv = 0; p_arv = 0;
            aw_hs_p = 0; w_hs_p = 0; ar_hs_p = 0; b_hs_p = 0; r_hs_p = 0;
            aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
            continue;
         end
         if (p_awv && !aw_hs_p && (!awvalid || awaddr != p_awa)) viol++;
         if (p_wv  && !w_hs_p  && (!wvalid  || wdata  != p_wd))  viol++;
         if (p_arv && !ar_hs_p && (!arvalid || araddr != p_ara)) viol++;
         if (aw_hs_p) begin aw_a = p_awa; aw_got = 1; end
         if (w_hs_p)  begin w_d  = p_wd;  w_got  = 1; end
         if (aw_got && w_got) begin
            automatic int ri = int'((aw_a - BASE) >> 2) & 3;
            chk("wr_addr", aw_a, exp_addr(wr_i));
            chk("wr_data", w_d, exp_data(wr_i));
            mem[ri] = (ri == stuck_reg) ? (w_d & ~32'd1) : w_d;
            b_code  = (ri == berr_reg) ? 2'b10 : 2'b00;
            b_pend = 1; b_cnt = 0; aw_got = 0; w_got = 0; wr_i++;
         end
         if (b_hs_p) begin bvalid = 0; b_pend = 0; end
         if (ar_hs_p) begin
            r_a = p_ara; r_pend = 1; r_cnt = 0; r_dly = $urandom_range(r_max, r_min);
         end
         if (r_hs_p) begin rvalid = 0; r_pend = 0; end
         if (b_pend && !bvalid) begin
            if (b_cnt >= b_dly) begin bvalid = 1; bresp = b_code; end
            else b_cnt++;
         end
         if (r_pend && !rvalid) begin
            if (r_cnt >= r_dly) begin rvalid = 1; rdata = mem[int'((r_a - BASE) >> 2) & 3]; rresp = 0; end
            else r_cnt++;
         end
         if (awvalid) begin awready = (aw_cnt >= aw_dly); aw_cnt++; end
         else begin awready = pre_rdy; aw_cnt = 0; end
         if (wvalid) begin wready = (w_cnt >= w_dly); w_cnt++; end
         else begin wready = pre_rdy; w_cnt = 0; end
         if (arvalid) begin arready = (ar_cnt >= ar_dly); ar_cnt++; end
         else begin arready = pre_rdy; ar_cnt = 0; end
         aw_hs_p = awvalid && awready; w_hs_p = wvalid && wready; ar_hs_p = arvalid && arready;
         b_hs_p  = bvalid && bready;   r_hs_p = rvalid && rready;
         p_awv = awvalid; p_awa = awaddr; p_wv = wvalid; p_wd = wdata; p_arv = arvalid; p_ara = araddr;
         if (busy) busy_cyc++;
         if (done) done_cyc++;
      end
   end

   // expected outcome derived from the pattern and the injected faults
   int          e_err, e_fidx;
   logic [31:0] e_frd;
   bit          e_resp;
   task automatic model();
      e_err = 0; e_fidx = 0; e_frd = 0; e_resp = 0;
      for (int i = 0; i < 4; i++) begin
         automatic logic [31:0] d  = exp_data(i);
         automatic logic [31:0] rb = (i == stuck_reg) ? (d & ~32'd1) : d;
`ifdef AXI_REGCHK_RESP_CHECK_EN
         if (i == berr_reg) begin
            if (e_err == 0) begin e_fidx = i; e_frd = 0; end
            e_err++; e_resp = 1;
         end
`endif
         if (rb != d) begin
            if (e_err == 0) begin e_fidx = i; e_frd = rb; end
            e_err++;
         end
      end
   endtask

   task automatic cfg(input int awd, input int wd, input int ard, input int bd,
                      input int rmn, input int rmx, input int stk, input int ber, input bit pre);
      aw_dly = awd; w_dly = wd; ar_dly = ard; b_dly = bd; r_min = rmn; r_max = rmx;
      stuck_reg = stk; berr_reg = ber; pre_rdy = pre;
   endtask

   task automatic launch(input logic [31:0] sd);
      seed_m = sd; wr_i = 0; viol = 0;
      @(negedge ACLK);
      busy_cyc = 0; done_cyc = 0;
      seed = sd; start = 1;
      @(negedge ACLK);
      start = 0; seed = $urandom;
   endtask

   task automatic run(input string nm, input logic [31:0] sd, input bit poke, input bit lat);
      int n;
      launch(sd);
      if (poke) begin
         repeat (3) @(negedge ACLK);
         seed = $urandom; start = 1;
         @(negedge ACLK);
         start = 0;
      end
      n = 0;
      while (!done && n < 3000) begin @(negedge ACLK); n++; end
      chk({nm, "_timeout"}, n >= 3000, 0);
      model();
      chk({nm, "_busy_at_done"}, busy, 0);
      chk({nm, "_pass"}, pass, e_err == 0);
      chk({nm, "_err_count"}, err_count, 8'(e_err));
      chk({nm, "_fail_index"}, fail_index, 8'(e_fidx));
      chk({nm, "_fail_rdata"}, fail_rdata, e_frd);
      chk({nm, "_resp_err"}, resp_err, e_resp);
      chk({nm, "_writes"}, wr_i, 4);
      chk({nm, "_stable"}, viol, 0);
      @(negedge ACLK);
      chk({nm, "_done_pulse"}, done_cyc, 1);
      chk({nm, "_pass_held"}, pass, e_err == 0);
      if (lat) chk({nm, "_busy_cycles"}, busy_cyc, 16);
   endtask

   initial begin
      int n;
      cfg(0, 0, 0, 0, 0, 0, -1, -1, 0);
      seed_m = 0;
      #1;
      chk("rst_ctl", {awvalid, wvalid, bready, arvalid, rready, busy, done, pass, resp_err}, 0);
      chk("rst_prot", {awprot, arprot}, 0);
      chk("rst_results", {err_count, fail_index, fail_rdata}, 0);
      repeat (3) @(negedge ACLK);
      ARESET = 0;

      cfg(0, 0, 0, 0, 0, 0, -1, -1, 0);
      run("zero_wait", 32'h0101FFFF, 0, 1);
      cfg(0, 0, 0, 0, 0, 0, 2, -1, 0);
      run("stuck_bit", 32'h0101FFFF, 0, 1);
      cfg(0, 3, 0, 0, 0, 5, -1, -1, 0);
      run("aw_before_w", 32'h0101FFFF, 0, 0);
      cfg(0, 0, 0, 0, 0, 0, -1, 1, 0);
      run("bresp_err", 32'h0101FFFF, 0, 1);
      cfg(1, 0, 2, 1, 0, 3, -1, -1, 0);
      run("start_busy", 32'hCAFE0001, 1, 0);

      for (int t = 0; t < 6; t++) begin
         automatic int stk = $urandom_range(4, 0);
         cfg($urandom_range(3, 0), $urandom_range(3, 0), $urandom_range(3, 0), $urandom_range(3, 0),
             0, 5, (stk == 4) ? -1 : stk, -1, 1'($urandom_range(1, 0)));
         run("random", $urandom, 0, 0);
      end

      // reset while reading back register 1, then a clean re-run
      cfg(0, 0, 0, 0, 3, 5, -1, -1, 0);
      launch(32'h0101FFFF);
      n = 0;
      while (!(wr_i == 2 && rready) && n < 500) begin @(negedge ACLK); n++; end
      chk("rst_mid_reached", n >= 500, 0);
      ARESET = 1;
      #1;
      chk("rst_mid_ctl", {awvalid, wvalid, bready, arvalid, rready, busy, done, pass}, 0);
      chk("rst_mid_results", {err_count, fail_index, fail_rdata}, 0);
      repeat (2) @(negedge ACLK);
      ARESET = 0;
      cfg(0, 0, 0, 0, 0, 0, -1, -1, 0);
      run("after_rst", 32'h0101FFFF, 0, 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
